issue_dispatch_ctrl: RTL and testbench
======================================

// Module: issue_dispatch_ctrl
// PURPOSE
//   Dispatch controller between rename and the reservation stations (issue_rs instances).
//   Registers one renamed instruction per cycle and steers it to the ALU, LSU or BRU/EPU RS by class.
//   ALU RS instances are shared round-robin, skipping full ones.
//   Applies backpressure to rename, drops state on flush, and counts dispatch stall cycles.
// PARAMETERS
//   PAYLOAD_W       128  width of packed issue payload (opcode bus, pc, imm, prs/prd, rob id/bank)
//   P_NUM_ALU_RS    1    log2 of number of ALU RS instances (NUM_ALU = 1<<P_NUM_ALU_RS)
//   CNT_W           16   width of stall counter
// PORTS
//   clk             in   1              core clock
//   rst             in   1              synchronous reset, active-low (0 = reset)
//   flush           in   1              pipeline flush, kills held instruction
//   rn_valid        in   1              rename has an instruction
//   rn_ready        out  1              controller accepts rn_* this cycle
//   rn_cls          in   3              class one-hot {bru_epu, lsu, alu}
//   rn_payload      in   PAYLOAD_W      instruction payload
//   alu_rs_full     in   NUM_ALU        issue_rs_full of each ALU RS
//   lsu_rs_full     in   1              issue_rs_full of LSU RS
//   bru_rs_full     in   1              issue_rs_full of BRU/EPU RS
//   alu_issue_push  out  NUM_ALU        issue_push to each ALU RS
//   lsu_issue_push  out  1              issue_push to LSU RS
//   bru_issue_push  out  1              issue_push to BRU/EPU RS
//   issue_payload   out  PAYLOAD_W      payload broadcast to all RS write ports
//   stall_cnt       out  CNT_W          saturating count of stalled dispatch cycles
// BEHAVIOUR
//   State:
//     - hold_vld, hold_cls, hold_payload form a 1-entry dispatch register.
//     - rr_ptr [P_NUM_ALU_RS-1:0] is the round-robin pointer.
//   Reset (rst=0 at posedge):
//     - hold_vld=0, hold_cls=0, hold_payload=0, rr_ptr=0, stall_cnt=0.
//     - While rst=0: all pushes=0 and rn_ready=0.
//   Target availability (combinational from hold):
//     - ALU: avail if any alu_rs_full[i]==0.
//       Target = first non-full index scanning rr_ptr, rr_ptr+1, ... mod NUM_ALU.
//     - LSU/BRU: avail = ~lsu_rs_full / ~bru_rs_full.
//   fire = hold_vld & avail & ~flush.
//     - Exactly one push bit high on fire, else all pushes 0.
//   issue_payload = hold_payload at all times; RS samples it with its push.
//   rn_ready = rst & ~flush & (~hold_vld | fire).
//     - Full throughput: 1 instr/cycle with no stalls.
//   Accept = rn_valid & rn_ready.
//     - On accept, hold <= rn_*, hold_vld <= 1.
//     - Else if fire, hold_vld <= 0.
//   Latency: accepted in cycle N -> push no earlier than cycle N+1.
//   rn_cls handling:
//     - Multi-hot: lowest set bit wins (alu > lsu > bru).
//     - rn_cls==0: accepted and discarded (hold_vld stays/becomes 0); no push ever.
//   Round-robin: after an ALU fire to index k, rr_ptr <= (k+1) mod NUM_ALU. Non-ALU fires leave rr_ptr unchanged.
//   Wrap: pointer wraps NUM_ALU-1 -> 0. With NUM_ALU=1, rr_ptr is constant 0.
//   Full: target RS full -> hold stays, push 0, rn_ready 0; payload/cls stable until fire.
//   Flush (rst=1, flush=1):
//     - Pushes=0, rn_ready=0, hold_vld<=0, rr_ptr<=0.
//     - stall_cnt unchanged and not incremented.
//     - Flush has priority over fire and accept in the same cycle.
//   Simultaneous fire+accept: new instr loaded, old one pushed; no bubble.
//   stall_cnt: +1 each cycle hold_vld & ~avail & ~flush; saturates at all-ones; cleared only by reset.
//   Full state must never change a push mid-cycle: pushes depend only on hold_*, *_full, rr_ptr, flush.
// TESTING
//   1) Reset: rst=0 for 2 cycles, rn_valid=1 -> rn_ready=0, pushes=0, stall_cnt=0; after rst=1, rn_ready=1.
//   2) ALU stream, 2 ALU RS none full, 4 back-to-back ALU instrs -> pushes alu[0],alu[1],alu[0],alu[1] in cycles 1-4; rn_ready=1 throughout.
//   3) alu_rs_full=2'b01, rr_ptr=0, ALU instr -> alu_issue_push=2'b10 next cycle; rr_ptr becomes 0 (wrap).
//   4) LSU instr with lsu_rs_full=1 for 5 cycles -> no push, rn_ready=0, stall_cnt=5; full drops -> lsu_issue_push=1 that cycle, same payload.
//   5) Flush with hold_vld=1, target free, rn_valid=1 -> no push, rn_ready=0; next cycle hold empty, rr_ptr=0.
//   6) stall_cnt at 16'hFFFF with persistent full -> remains 16'hFFFF; rn_cls=3'b000 accepted -> no push, no stall count.

Source files
------------

// File: rtl/issue_dispatch_if.sv
// Rename-to-RS dispatch bundle: rename handshake, RS full flags, RS pushes and the shared payload bus.
interface issue_dispatch_if #(
  parameter int PAYLOAD_W = 128,
  parameter int NUM_ALU   = 2
);
  logic                 rn_valid;
  logic                 rn_ready;
  logic [2:0]           rn_cls;
  logic [PAYLOAD_W-1:0] rn_payload;
  logic [NUM_ALU-1:0]   alu_rs_full;
  logic                 lsu_rs_full;
  logic                 bru_rs_full;
  logic [NUM_ALU-1:0]   alu_issue_push;
  logic                 lsu_issue_push;
  logic                 bru_issue_push;
  logic [PAYLOAD_W-1:0] issue_payload;

  modport master (
    input  rn_valid, rn_cls, rn_payload, alu_rs_full, lsu_rs_full, bru_rs_full,
    output rn_ready, alu_issue_push, lsu_issue_push, bru_issue_push, issue_payload
  );

  modport slave (
    output rn_valid, rn_cls, rn_payload, alu_rs_full, lsu_rs_full, bru_rs_full,
    input  rn_ready, alu_issue_push, lsu_issue_push, bru_issue_push, issue_payload
  );
endinterface

// File: rtl/issue_dispatch_ctrl.sv
// One-entry dispatch register between rename and the reservation stations; steers by class,
// round-robins across ALU RS instances and counts stalled dispatch cycles.
module issue_dispatch_ctrl #(
  parameter int PAYLOAD_W    = 128,
  parameter int P_NUM_ALU_RS = 1,
  parameter int CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  issue_dispatch_if.master    dif,
  output logic [CNT_W-1:0]    stall_cnt
);
  localparam int NUM_ALU = 1 << P_NUM_ALU_RS;
  localparam int PTR_W   = (P_NUM_ALU_RS > 0) ? P_NUM_ALU_RS : 1;

  logic                 hold_vld;
  logic [2:0]           hold_cls;
  logic [PAYLOAD_W-1:0] hold_payload;
  logic [PTR_W-1:0]     rr_ptr, alu_tgt, rr_nxt;
  logic                 alu_avail, is_alu, is_lsu, is_bru, avail, fire, accept;

  // Scan from rr_ptr upward; descending loop so the smallest offset wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx       = '0;
    alu_avail = 1'b0;
    alu_tgt   = '0;
    for (int off = NUM_ALU - 1; off >= 0; off--) begin
      idx = rr_ptr + PTR_W'(off);
      if (!dif.alu_rs_full[idx]) begin
        alu_avail = 1'b1;
        alu_tgt   = idx;
      end
    end
    rr_nxt = (NUM_ALU == 1) ? '0 : alu_tgt + 1'b1;
  end

  // Multi-hot class: lowest set bit wins.
  assign is_alu = hold_cls[0];
  assign is_lsu = hold_cls[1] & ~hold_cls[0];
  assign is_bru = hold_cls[2] & ~|hold_cls[1:0];

  assign avail  = (is_alu & alu_avail) | (is_lsu & ~dif.lsu_rs_full) | (is_bru & ~dif.bru_rs_full);
  assign fire   = rst & ~flush & hold_vld & avail;
  assign dif.rn_ready = rst & ~flush & (~hold_vld | fire);
  assign accept = dif.rn_valid & dif.rn_ready;

  for (genvar i = 0; i < NUM_ALU; i++) begin : g_alu_push
    assign dif.alu_issue_push[i] = fire & is_alu & (alu_tgt == PTR_W'(i));
  end
  assign dif.lsu_issue_push = fire & is_lsu;
  assign dif.bru_issue_push = fire & is_bru;
  assign dif.issue_payload  = hold_payload;

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_vld     <= 1'b0;
      hold_cls     <= '0;
      hold_payload <= '0;
      rr_ptr       <= '0;
      stall_cnt    <= '0;
    end else if (flush) begin
      hold_vld <= 1'b0;
      rr_ptr   <= '0;
    end else begin
      // A class-less instruction is consumed but never becomes valid.
      if (accept) begin
        hold_vld     <= |dif.rn_cls;
        hold_cls     <= dif.rn_cls;
        hold_payload <= dif.rn_payload;
      end else if (fire) begin
        hold_vld <= 1'b0;
      end
      if (fire && is_alu)
        rr_ptr <= rr_nxt;
      if (hold_vld && !avail && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_issue_dispatch_ctrl.sv
// Bench for issue_dispatch_ctrl: vector table plus directed stall/flush/saturation sequences,
// with a push scoreboard checked on every falling edge.
module tb_issue_dispatch_ctrl;
  localparam int PW = 128;
  localparam int NA = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  issue_dispatch_if #(.PAYLOAD_W(PW), .NUM_ALU(NA)) dif();

  issue_dispatch_ctrl #(.PAYLOAD_W(PW), .P_NUM_ALU_RS(1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .dif(dif), .stall_cnt(stall_cnt)
  );

  typedef struct packed { logic [3:0] push; logic [PW-1:0] pl; } exp_t;
  typedef struct { logic [2:0] cls; logic [1:0] af; logic lf; logic bf; logic [3:0] exp; } vec_t;

  exp_t    sb[$];
  exp_t    mon_e;
  vec_t    tbl[10];
  int      n_cmp = 0;
  int      n_err = 0;
  logic [PW-1:0] pl, pl_prev;

  task automatic check(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // {alu[1], alu[0], lsu, bru}
  function automatic logic [3:0] pushes();
    return {dif.alu_issue_push, dif.lsu_issue_push, dif.bru_issue_push};
  endfunction

  function automatic logic [PW-1:0] rp();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && pushes() != 4'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_push", PW'(pushes()), PW'(0));
      end else begin
        mon_e = sb.pop_front();
        check("sb_push_vec", PW'(pushes()), PW'(mon_e.push));
        check("sb_payload", dif.issue_payload, mon_e.pl);
      end
    end
  end

  initial begin
    tbl[0] = '{3'b001, 2'b01, 1'b0, 1'b0, 4'b1000};
    tbl[1] = '{3'b001, 2'b00, 1'b0, 1'b0, 4'b0100};
    tbl[2] = '{3'b001, 2'b10, 1'b0, 1'b0, 4'b0100};
    tbl[3] = '{3'b010, 2'b11, 1'b0, 1'b0, 4'b0010};
    tbl[4] = '{3'b100, 2'b11, 1'b0, 1'b0, 4'b0001};
    tbl[5] = '{3'b011, 2'b00, 1'b0, 1'b0, 4'b1000};
    tbl[6] = '{3'b110, 2'b00, 1'b0, 1'b0, 4'b0010};
    tbl[7] = '{3'b000, 2'b00, 1'b0, 1'b0, 4'b0000};
    tbl[8] = '{3'b111, 2'b01, 1'b0, 1'b0, 4'b1000};
    tbl[9] = '{3'b001, 2'b00, 1'b0, 1'b0, 4'b0100};

    rst = 1'b0; flush = 1'b0;
    dif.rn_valid = 1'b1; dif.rn_cls = 3'b001; dif.rn_payload = rp();
    dif.alu_rs_full = '0; dif.lsu_rs_full = 1'b0; dif.bru_rs_full = 1'b0;
    pl = '0; pl_prev = '0;

    // Reset
    for (int i = 0; i < 2; i++) begin
      cyc();
      @(negedge clk);
      check("rst_rn_ready", PW'(dif.rn_ready), PW'(0));
      check("rst_pushes", PW'(pushes()), PW'(0));
      check("rst_stall_cnt", PW'(stall_cnt), PW'(0));
    end
    cyc();
    rst = 1'b1; dif.rn_valid = 1'b0;
    @(negedge clk);
    check("post_rst_rn_ready", PW'(dif.rn_ready), PW'(1));

    // Back-to-back ALU stream; push for instr k appears one cycle after it is driven
    for (int i = 0; i < 5; i++) begin
      cyc();
      pl_prev = pl;
      if (i < 4) begin
        pl = rp();
        dif.rn_valid = 1'b1; dif.rn_cls = 3'b001; dif.rn_payload = pl;
      end else begin
        dif.rn_valid = 1'b0;
      end
      if (i > 0) sb.push_back('{((i - 1) % 2 == 0) ? 4'b0100 : 4'b1000, pl_prev});
      @(negedge clk);
      if (i < 4) check("stream_rn_ready", PW'(dif.rn_ready), PW'(1));
    end

    // Vector table, one instruction at a time
    for (int i = 0; i < 10; i++) begin
      cyc();
      pl = rp();
      dif.rn_valid = 1'b1; dif.rn_cls = tbl[i].cls; dif.rn_payload = pl;
      dif.alu_rs_full = tbl[i].af; dif.lsu_rs_full = tbl[i].lf; dif.bru_rs_full = tbl[i].bf;
      @(negedge clk);
      check("tbl_rn_ready", PW'(dif.rn_ready), PW'(1));
      cyc();
      dif.rn_valid = 1'b0;
      if (tbl[i].exp != 4'b0) sb.push_back('{tbl[i].exp, pl});
      @(negedge clk);
      check($sformatf("tbl%0d_push", i), PW'(pushes()), PW'(tbl[i].exp));
    end
    cyc();
    dif.alu_rs_full = '0;
    @(negedge clk);
    check("tbl_stall_cnt", PW'(stall_cnt), PW'(0));

    // LSU held against a full RS for 5 cycles
    cyc();
    pl = rp();
    dif.rn_valid = 1'b1; dif.rn_cls = 3'b010; dif.rn_payload = pl; dif.lsu_rs_full = 1'b1;
    @(negedge clk);
    cyc();
    dif.rn_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("lsu_full_rn_ready", PW'(dif.rn_ready), PW'(0));
      check("lsu_full_stall_cnt", PW'(stall_cnt), PW'(i));
      check("lsu_full_payload", dif.issue_payload, pl);
      cyc();
    end
    dif.lsu_rs_full = 1'b0;
    sb.push_back('{4'b0010, pl});
    @(negedge clk);
    check("lsu_release_push", PW'(pushes()), PW'(4'b0010));
    check("lsu_release_stall_cnt", PW'(stall_cnt), PW'(5));

    // Flush with a fireable held instruction (rr_ptr is 1 here)
    cyc();
    pl = rp();
    dif.rn_valid = 1'b1; dif.rn_cls = 3'b001; dif.rn_payload = pl;
    @(negedge clk);
    cyc();
    flush = 1'b1; dif.rn_cls = 3'b010; dif.rn_payload = rp();
    @(negedge clk);
    check("flush_pushes", PW'(pushes()), PW'(0));
    check("flush_rn_ready", PW'(dif.rn_ready), PW'(0));
    cyc();
    flush = 1'b0; dif.rn_valid = 1'b0;
    @(negedge clk);
    check("post_flush_pushes", PW'(pushes()), PW'(0));
    check("post_flush_rn_ready", PW'(dif.rn_ready), PW'(1));
    cyc();
    pl = rp();
    dif.rn_valid = 1'b1; dif.rn_cls = 3'b001; dif.rn_payload = pl;
    @(negedge clk);
    cyc();
    dif.rn_valid = 1'b0;
    sb.push_back('{4'b0100, pl});
    @(negedge clk);
    check("flush_rr_reset", PW'(pushes()), PW'(4'b0100));

    // Flush while stalled must not count
    cyc();
    dif.rn_valid = 1'b1; dif.rn_cls = 3'b001; dif.rn_payload = rp(); dif.alu_rs_full = 2'b11;
    @(negedge clk);
    cyc();
    dif.rn_valid = 1'b0;
    @(negedge clk);
    check("alu_full_stall_cnt", PW'(stall_cnt), PW'(5));
    cyc();
    flush = 1'b1;
    @(negedge clk);
    check("flush_stall_cnt_a", PW'(stall_cnt), PW'(6));
    cyc();
    flush = 1'b0; dif.alu_rs_full = 2'b00;
    @(negedge clk);
    check("flush_stall_cnt_b", PW'(stall_cnt), PW'(6));
    check("flush_dropped_hold", PW'(pushes()), PW'(0));

    // Saturation
    cyc();
    dif.rn_valid = 1'b1; dif.rn_cls = 3'b010; dif.rn_payload = rp(); dif.lsu_rs_full = 1'b1;
    @(negedge clk);
    cyc();
    dif.rn_valid = 1'b0;
    for (int k = 0; k < 70000 && stall_cnt != 16'hFFFF; k++) cyc();
    check("sat_reach", PW'(stall_cnt), PW'(16'hFFFF));
    for (int i = 0; i < 3; i++) cyc();
    @(negedge clk);
    check("sat_hold", PW'(stall_cnt), PW'(16'hFFFF));
    check("sat_no_push", PW'(pushes()), PW'(0));
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    dif.rn_valid = 1'b1; dif.rn_cls = 3'b000; dif.rn_payload = rp();
    @(negedge clk);
    check("cls0_rn_ready", PW'(dif.rn_ready), PW'(1));
    cyc();
    dif.rn_valid = 1'b0;
    @(negedge clk);
    check("cls0_no_push", PW'(pushes()), PW'(0));
    check("cls0_rn_ready_after", PW'(dif.rn_ready), PW'(1));
    check("cls0_stall_cnt", PW'(stall_cnt), PW'(16'hFFFF));

    cyc();
    check("sb_drained", PW'(sb.size()), PW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
